// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory request/ack on one side,
// decoded instruction valid/ready plus redirect controls on the other.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch_taken;
  logic        jump;
  logic        flush;
  logic [31:0] flush_pc;
  logic        misalign;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr_valid,
    input  instr_ready,
    output instr, opcode, funct, rs, rt, rd, imm16,
    output pc, pc_plus4,
    input  branch_taken, jump, flush, flush_pc,
    output misalign
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr_valid,
    output instr_ready,
    input  instr, opcode, funct, rs, rt, rd, imm16,
    input  pc, pc_plus4,
    output branch_taken, jump, flush, flush_pc,
    input  misalign
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch stage: PC, imem req/ack fetch, next-PC
// selection for branch/jump/flush, and kill of stale in-flight fetches.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    KILL,
    VALID
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        mis_q, mis_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] jmp_pc;
  logic [31:0] flush_al;
  logic [31:0] seq_pc;
  logic        ack;
  logic        handoff;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign jmp_pc   = {pc_plus4[31:28], instr_q[25:0], 2'b00};
  assign flush_al = {bus.flush_pc[31:2], 2'b00};
  assign ack      = bus.imem_req & bus.imem_ack;
  assign handoff  = (state_q == VALID) & bus.instr_ready;

  always_comb begin
    seq_pc = pc_plus4;
    unique case (1'b1)
      bus.jump:                      seq_pc = jmp_pc;
      !bus.jump && bus.branch_taken: seq_pc = pc_plus4 + br_off;
      !bus.jump && !bus.branch_taken: seq_pc = pc_plus4;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tgt_d   = tgt_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    mis_d   = bus.flush & (bus.flush_pc[1:0] != 2'b00);
    if (bus.flush) begin
      // An issued request must still complete; park in KILL until acked.
      unique case (state_q)
        IDLE, VALID: begin
          state_d = REQ;
          addr_d  = flush_al;
        end
        REQ, KILL: begin
          if (ack) begin
            state_d = REQ;
            addr_d  = flush_al;
          end else begin
            state_d = KILL;
            tgt_d   = flush_al;
          end
        end
      endcase
    end else begin
      unique case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (ack) begin
            state_d = VALID;
            instr_d = bus.imem_rdata;
            pc_d    = addr_q;
          end
        end
        KILL: begin
          if (ack) begin
            state_d = REQ;
            addr_d  = tgt_q;
          end
        end
        VALID: begin
          if (handoff) begin
            state_d = REQ;
            addr_d  = seq_pc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= RESET_PC;
      tgt_q   <= RESET_PC;
      instr_q <= 32'h0;
      pc_q    <= RESET_PC;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tgt_q   <= tgt_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end

  assign bus.imem_req    = (state_q == REQ) || (state_q == KILL);
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = (state_q == VALID);
  assign bus.instr       = instr_q;
  assign bus.opcode      = instr_q[31:26];
  assign bus.funct       = instr_q[5:0];
  assign bus.rs          = instr_q[25:21];
  assign bus.rt          = instr_q[20:16];
  assign bus.rd          = instr_q[15:11];
  assign bus.imm16       = instr_q[15:0];
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.misalign    = mis_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-programmable
// instruction memory model and hand-computed expectations.
module tb_instr_fetch_unit;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   lat;
  int   cnt;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h2008_0005;
      32'h0000_0100: mem_word = 32'h1000_FFFE;
      32'h3000_0010: mem_word = 32'h0800_0040;
      32'h0000_0020: mem_word = 32'hDEAD_BEEF;
      32'h0000_0400: mem_word = 32'h2009_0007;
      default:       mem_word = a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // memory model: ack after 'lat' waiting cycles, zero-wait when lat==0
  always @(negedge clk) begin
    if (!bus.imem_req) begin
      bus.imem_ack = 1'b0;
      cnt = 0;
    end else begin
      if (bus.imem_ack) cnt = 0;
      if (cnt >= lat) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(bus.imem_addr);
      end else begin
        bus.imem_ack = 1'b0;
        cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic flush_to(input logic [31:0] a);
    bus.flush    = 1'b1;
    bus.flush_pc = a;
    cyc();
    bus.flush    = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40 && !bus.instr_valid; i++) cyc();
    chk(tag, 32'(bus.instr_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        stale;
    logic [31:0] first_new;
    logic        seen_new;
    n_cmp = 0;
    n_bad = 0;
    lat   = 0;
    cnt   = 0;
    rst   = 1'b1;
    bus.imem_ack     = 1'b0;
    bus.imem_rdata   = 32'h0;
    bus.instr_ready  = 1'b0;
    bus.branch_taken = 1'b0;
    bus.jump         = 1'b0;
    bus.flush        = 1'b0;
    bus.flush_pc     = 32'h0;
    repeat (3) cyc();
    chk("rst_req",   32'(bus.imem_req), 32'd0);
    chk("rst_addr",  bus.imem_addr, 32'h0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_pc",    bus.pc, 32'h0);
    chk("rst_mis",   32'(bus.misalign), 32'd0);

    // zero-wait first fetch
    rst = 1'b0;
    cyc();
    chk("c1_req",  32'(bus.imem_req), 32'd1);
    chk("c1_addr", bus.imem_addr, 32'h0);
    cyc();
    chk("c2_valid",  32'(bus.instr_valid), 32'd1);
    chk("c2_opcode", 32'(bus.opcode), 32'h08);
    chk("c2_rt",     32'(bus.rt), 32'd8);
    chk("c2_rs",     32'(bus.rs), 32'd0);
    chk("c2_imm",    32'(bus.imm16), 32'h0005);
    chk("c2_pc",     bus.pc, 32'h0);
    chk("c2_pc4",    bus.pc_plus4, 32'h4);
    bus.instr_ready = 1'b1;
    cyc();
    bus.instr_ready = 1'b0;
    chk("seq_req",   32'(bus.imem_req), 32'd1);
    chk("seq_addr",  bus.imem_addr, 32'h4);
    chk("seq_valid", 32'(bus.instr_valid), 32'd0);
    wait_valid("seq_v");

    // taken branch backwards
    flush_to(32'h100);
    chk("br_req_addr", bus.imem_addr, 32'h100);
    wait_valid("br_v");
    chk("br_instr", bus.instr, 32'h1000_FFFE);
    chk("br_pc",    bus.pc, 32'h100);
    bus.instr_ready  = 1'b1;
    bus.branch_taken = 1'b1;
    cyc();
    bus.instr_ready  = 1'b0;
    bus.branch_taken = 1'b0;
    chk("br_t_addr", bus.imem_addr, 32'h0FC);
    chk("br_t_req",  32'(bus.imem_req), 32'd1);
    wait_valid("br_t_v");
    chk("br_t_pc", bus.pc, 32'h0FC);

    // not-taken branch
    flush_to(32'h100);
    wait_valid("br_n_v");
    bus.instr_ready = 1'b1;
    cyc();
    bus.instr_ready = 1'b0;
    chk("br_n_addr", bus.imem_addr, 32'h104);
    wait_valid("br_n_v2");

    // jump beats branch
    flush_to(32'h3000_0010);
    wait_valid("j_v");
    chk("j_instr", bus.instr, 32'h0800_0040);
    bus.instr_ready  = 1'b1;
    bus.jump         = 1'b1;
    bus.branch_taken = 1'b1;
    cyc();
    bus.instr_ready  = 1'b0;
    bus.jump         = 1'b0;
    bus.branch_taken = 1'b0;
    chk("j_addr", bus.imem_addr, 32'h3000_0100);
    wait_valid("j_v2");

    // flush during a 3-cycle fetch kills the stale response
    lat = 3;
    flush_to(32'h20);
    flush_to(32'h400);
    chk("k_req",  32'(bus.imem_req), 32'd1);
    chk("k_addr", bus.imem_addr, 32'h20);
    stale     = 1'b0;
    seen_new  = 1'b0;
    first_new = 32'h0;
    for (int i = 0; i < 40 && !bus.instr_valid; i++) begin
      cyc();
      if (bus.instr_valid && bus.pc == 32'h20) stale = 1'b1;
      if (!seen_new && bus.imem_req && bus.imem_addr != 32'h20) begin
        seen_new  = 1'b1;
        first_new = bus.imem_addr;
      end
    end
    chk("k_valid", 32'(bus.instr_valid), 32'd1);
    chk("k_stale", 32'(stale), 32'd0);
    chk("k_next",  first_new, 32'h400);
    chk("k_pc",    bus.pc, 32'h400);
    chk("k_instr", bus.instr, 32'h2009_0007);

    // stall, then misaligned flush
    lat = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("st_req",   32'(bus.imem_req), 32'd0);
      chk("st_valid", 32'(bus.instr_valid), 32'd1);
      chk("st_pc",    bus.pc, 32'h400);
      chk("st_instr", bus.instr, 32'h2009_0007);
    end
    flush_to(32'h203);
    chk("ma_mis",   32'(bus.misalign), 32'd1);
    chk("ma_addr",  bus.imem_addr, 32'h200);
    chk("ma_req",   32'(bus.imem_req), 32'd1);
    chk("ma_valid", 32'(bus.instr_valid), 32'd0);
    cyc();
    chk("ma_mis2", 32'(bus.misalign), 32'd0);
    wait_valid("ma_v");
    chk("ma_pc", bus.pc, 32'h200);

    // reset while a request waits for ack
    lat = 20;
    flush_to(32'h40);
    chk("rr_req",  32'(bus.imem_req), 32'd1);
    chk("rr_addr", bus.imem_addr, 32'h40);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    chk("rr_req0",  32'(bus.imem_req), 32'd0);
    chk("rr_valid", 32'(bus.instr_valid), 32'd0);
    chk("rr_pc",    bus.pc, 32'h0);
    chk("rr_addr0", bus.imem_addr, 32'h0);
    rst = 1'b0;
    lat = 0;
    wait_valid("rr_v");
    chk("rr_pc2",   bus.pc, 32'h0);
    chk("rr_instr", bus.instr, 32'h2008_0005);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage sitting directly upstream of the decode/control unit. It holds the program counter, fetches 32-bit MIPS instructions from instruction memory over a request/acknowledge handshake, and presents the instruction plus pre-split fields (opcode, funct, rs, rt, rd, imm16) to decode under a valid/ready handshake. It computes the next PC from sequential flow, taken BEQ/BNE branches, J jumps, and an asynchronous-to-pipeline flush, discarding any in-flight fetch that a flush makes stale.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request, held until acknowledged
- imem_addr  out  32  fetch address, stable while imem_req=1
- imem_ack  in  1  request accepted and imem_rdata valid this cycle
- imem_rdata  in  32  instruction word, sampled only when imem_req & imem_ack
- instr_valid  out  1  instruction register holds a valid instruction
- instr_ready  in  1  decode accepts instruction (handoff = instr_valid & instr_ready)
- instr  out  32  held instruction word
- opcode  out  6  instr[31:26]; funct out 6 instr[5:0]; rs/rt/rd out 5 each instr[25:21]/[20:16]/[15:11]; imm16 out 16 instr[15:0]
- pc  out  32  address of held instruction; pc_plus4 out 32 pc+4
- branch_taken  in  1  sampled at handoff; branch of held instruction is taken
- jump  in  1  sampled at handoff; held instruction is J
- flush  in  1  discard everything, restart at flush_pc (any cycle)
- flush_pc  in  32  restart address; bits [1:0] forced to 0
- misalign  out  1  one-cycle pulse when flush_pc[1:0] != 0 was accepted

## Operation
- States: IDLE, REQ, KILL, VALID.
- IDLE: entered on reset; next cycle -> REQ with imem_addr = fetch PC.
- REQ: imem_req=1. On imem_ack: instr <= imem_rdata, pc <= imem_addr, -> VALID.
- VALID: instr_valid=1; instruction and fields stable until handoff. On handoff, next fetch PC chosen, priority: jump > branch_taken > sequential:
  - jump: {pc_plus4[31:28], instr[25:0], 2'b00}
  - branch_taken: pc_plus4 + (sign-extended imm16 << 2), 32-bit wrap-around
  - else pc_plus4 (0xFFFF_FFFC + 4 wraps to 0)
  - then -> REQ. branch_taken/jump ignored when no handoff.
- flush (highest priority over everything except rst): fetch PC <= {flush_pc[31:2],2'b00}; instr_valid cleared next cycle.
  - from IDLE/VALID: -> REQ.
  - from REQ without ack this cycle: -> KILL (request already issued must complete). With ack this cycle: data dropped, -> REQ.
  - KILL: imem_req=1 at the stale address; on ack data dropped, -> REQ at flush PC. Further flush in KILL updates the flush PC, stays KILL.
- Decode never sees a killed instruction.
- misalign pulses the cycle after a flush with flush_pc[1:0] != 0.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, instr_valid 0, instr 32'h0 (NOP, so opcode/funct 0), pc RESET_PC, misalign 0. rst mid-fetch abandons the request (imem_req drops next cycle); memory must tolerate it.
- First request: cycle after rst deasserts.
- Zero-wait memory (ack same cycle as req): instr_valid one cycle after ack; steady-state throughput one instruction per 2 cycles with instr_ready=1.
- imem_addr never changes while imem_req=1 and ack not received.
- Outputs are registered except fields (pure slices of instr) and pc_plus4.
- Stall: instr_ready=0 holds VALID indefinitely, no new request issued.

## Test plan
- Reset, zero-wait memory returning 0x2008_0005 at 0, ready=1 -> first req cycle 1 at 0x0, instr_valid cycle 2 with opcode 0x08, rt 8, imm16 0x0005; next req at 0x4.
- Branch: pc=0x100, instr 0x1000_FFFE, branch_taken at handoff -> next imem_addr 0x0FC; same with branch_taken=0 -> 0x104.
- Jump: pc=0x3000_0010, instr 0x0800_0040, jump=1 with branch_taken=1 -> next imem_addr 0x3000_0100 (jump wins).
- Flush during 3-cycle-latency fetch at 0x20, flush_pc 0x400 -> KILL, stale data never valid, next req at 0x400.
- Stall: instr_ready=0 for 5 cycles in VALID -> instr/pc constant, imem_req 0; flush_pc 0x203 -> fetch at 0x200, misalign pulses once.
- rst asserted in REQ with ack pending -> next cycle imem_req 0, instr_valid 0, pc RESET_PC.
